// File: rtl/chacha_block_core.sv
// ChaCha block function: one full round per clock using four parallel
// quarter-round instances, with the keystream block on a valid/ready output.

module qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] ya,
    output logic [31:0] yb,
    output logic [31:0] yc,
    output logic [31:0] yd
);
    logic [31:0] a1, b1, c1, d1, a2, c2, dx1, bx1, dx2, bx2;

    always_comb begin
        a1  = a + b;
        dx1 = d ^ a1;
        d1  = {dx1[15:0], dx1[31:16]};
        c1  = c + d1;
        bx1 = b ^ c1;
        b1  = {bx1[19:0], bx1[31:20]};
        a2  = a1 + b1;
        dx2 = d1 ^ a2;
        yd  = {dx2[23:0], dx2[31:24]};
        c2  = c1 + yd;
        bx2 = b1 ^ c2;
        yb  = {bx2[24:0], bx2[31:25]};
        ya  = a2;
        yc  = c2;
    end
endmodule

module chacha_block_core #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [4:0] LAST_RND = 5'(2 * DOUBLE_ROUNDS - 1);

    state_t      state;
    logic [4:0]  rnd;
    logic [31:0] work       [16];
    logic [31:0] init_st    [16];
    logic [31:0] load_st    [16];
    logic [31:0] next_work  [16];
    logic [31:0] qa [4], qb [4], qc [4], qd [4];
    logic [31:0] ya [4], yb [4], yc [4], yd [4];

    always_comb begin
        load_st[0] = 32'h61707865;
        load_st[1] = 32'h3320646e;
        load_st[2] = 32'h79622d32;
        load_st[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) load_st[4+i] = key[32*i +: 32];
        load_st[12] = counter;
        for (int i = 0; i < 3; i++) load_st[13+i] = nonce[32*i +: 32];
    end

    // Diagonal rounds rotate rows b, c, d left by 1, 2, 3 columns; the
    // write-back uses the same mapping so words land where they came from.
    always_comb begin
        for (int i = 0; i < 16; i++) next_work[i] = work[i];
        for (int i = 0; i < 4; i++) begin
            qa[i] = work[i];
            if (!rnd[0]) begin
                qb[i] = work[4+i];
                qc[i] = work[8+i];
                qd[i] = work[12+i];
                next_work[4+i]  = yb[i];
                next_work[8+i]  = yc[i];
                next_work[12+i] = yd[i];
            end else begin
                qb[i] = work[4+((i+1)%4)];
                qc[i] = work[8+((i+2)%4)];
                qd[i] = work[12+((i+3)%4)];
                next_work[4+((i+1)%4)]  = yb[i];
                next_work[8+((i+2)%4)]  = yc[i];
                next_work[12+((i+3)%4)] = yd[i];
            end
            next_work[i] = ya[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        qr u_qr (
            .a (qa[g]), .b (qb[g]), .c (qc[g]), .d (qd[g]),
            .ya(ya[g]), .yb(yb[g]), .yc(yc[g]), .yd(yd[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
                work[i]    <= '0;
                init_st[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            work[i]    <= load_st[i];
                            init_st[i] <= load_st[i];
                        end
                        rnd   <= '0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    for (int i = 0; i < 16; i++) work[i] <= next_work[i];
                    if (rnd == LAST_RND) state <= FINAL;
                    else                 rnd   <= rnd + 5'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++)
                        out_block[32*i +: 32] <= work[i] + init_st[i];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule
